// File: rtl/r_port_arbiter_pkg.sv
// Shared types and sizing helpers for the row_matrix port arbiter.
package r_port_arbiter_pkg;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  // One slot per in-flight read plus one so a push can overlap a pop.
  function automatic int owner_fifo_depth(input int mem_latency);
    return mem_latency + 1;
  endfunction

endpackage

// File: rtl/r_port_arbiter_if.sv
// Requester-side handshake bundle: one instance per requester (A or B).
interface r_port_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int ROW_W  = 160
);
  logic [ADDR_W-1:0] row_addr;
  logic              row_addr_ready;
  logic              row_addr_ack;
  logic              row_valid;
  logic [ADDR_W-1:0] write_row_addr;
  logic [ROW_W-1:0]  write_data;
  logic              write_ready;
  logic              write_ack;

  modport master (
    output row_addr, row_addr_ready, write_row_addr, write_data, write_ready,
    input  row_addr_ack, row_valid, write_ack
  );

  modport slave (
    input  row_addr, row_addr_ready, write_row_addr, write_data, write_ready,
    output row_addr_ack, row_valid, write_ack
  );
endinterface

// File: rtl/r_port_arbiter_owner_fifo.sv
// Tracks which requester owns each outstanding read, in issue order.
module owner_fifo
  import r_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  owner_e push_owner_i,
  input  logic   pop_i,
  output owner_e pop_owner_o,
  output logic   full_o,
  output logic   empty_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  owner_e            mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push_s, do_pop_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
  endfunction

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == {CNT_W{1'b0}});
  assign pop_owner_o = mem_q[rd_ptr_q];
  assign do_pop_s    = pop_i & ~empty_o;
  assign do_push_s   = push_i & (~full_o | do_pop_s);

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= OWNER_A;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_owner_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop_s) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/r_port_arbiter.sv
// Two-requester round-robin arbiter for a shared row_matrix with independent
// read and write channels and in-order read response routing.
module r_port_arbiter
  import r_port_arbiter_pkg::*;
#(
  parameter int NUM_ROWS       = 5,
  parameter int NUM_COLS       = 5,
  parameter int SCALAR_BITS    = 32,
  parameter int MEMORY_LATENCY = 2,
  localparam int ADDR_W = $clog2(NUM_ROWS),
  localparam int ROW_W  = NUM_COLS * SCALAR_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a_row_addr,
  input  logic [ADDR_W-1:0] b_row_addr,
  input  logic              a_row_addr_ready,
  input  logic              b_row_addr_ready,
  output logic              a_row_addr_ack,
  output logic              b_row_addr_ack,
  output logic              a_row_valid,
  output logic              b_row_valid,
  output logic [ROW_W-1:0]  row_out,
  input  logic [ADDR_W-1:0] a_write_row_addr,
  input  logic [ADDR_W-1:0] b_write_row_addr,
  input  logic [ROW_W-1:0]  a_write_data,
  input  logic [ROW_W-1:0]  b_write_data,
  input  logic              a_write_ready,
  input  logic              b_write_ready,
  output logic              a_write_ack,
  output logic              b_write_ack,
  output logic [ADDR_W-1:0] m_row_addr,
  output logic              m_row_addr_ready,
  output logic [ADDR_W-1:0] m_write_row_addr,
  output logic [ROW_W-1:0]  m_write_data,
  output logic              m_write_ready,
  input  logic              m_row_valid,
  input  logic [ROW_W-1:0]  m_row_out,
  output logic              resp_error
);
  localparam int FIFO_DEPTH = owner_fifo_depth(MEMORY_LATENCY);

  logic   rd_last_a_q, rd_last_a_d, wr_last_a_q, wr_last_a_d;
  logic   resp_error_q, resp_error_d;
  logic   rd_a_s, rd_b_s, rd_grant_a_s, rd_grant_b_s;
  logic   wr_grant_a_s, wr_grant_b_s;
  logic   fifo_full_s, fifo_empty_s, pop_s, unexpected_s;
  owner_e pop_owner_s;

  // Grant decode: purely combinational so requests reach memory the same cycle.
  always_comb begin
    // A full FIFO still accepts a read when a response frees a slot this cycle.
    rd_a_s       = a_row_addr_ready & (~fifo_full_s | m_row_valid) & ~rst;
    rd_b_s       = b_row_addr_ready & (~fifo_full_s | m_row_valid) & ~rst;
    rd_grant_a_s = rd_a_s & (~rd_b_s | ~rd_last_a_q);
    rd_grant_b_s = rd_b_s & ~rd_grant_a_s;
    wr_grant_a_s = a_write_ready & ~rst & (~(b_write_ready & ~rst) | ~wr_last_a_q);
    wr_grant_b_s = b_write_ready & ~rst & ~wr_grant_a_s;
    pop_s        = m_row_valid & ~fifo_empty_s & ~rst;
    unexpected_s = m_row_valid & fifo_empty_s & ~rst;

    if (rd_grant_a_s)      rd_last_a_d = 1'b1;
    else if (rd_grant_b_s) rd_last_a_d = 1'b0;
    else                   rd_last_a_d = rd_last_a_q;
    if (wr_grant_a_s)      wr_last_a_d = 1'b1;
    else if (wr_grant_b_s) wr_last_a_d = 1'b0;
    else                   wr_last_a_d = wr_last_a_q;
    resp_error_d = resp_error_q | unexpected_s;
  end

  // Memory-side request mux and requester-side acks/valids.
  always_comb begin
    m_row_addr_ready = rd_grant_a_s | rd_grant_b_s;
    m_write_ready    = wr_grant_a_s | wr_grant_b_s;
    if (rd_grant_b_s)      m_row_addr = b_row_addr;
    else if (rd_grant_a_s) m_row_addr = a_row_addr;
    else                   m_row_addr = {ADDR_W{1'b0}};
    if (wr_grant_b_s) begin
      m_write_row_addr = b_write_row_addr;
      m_write_data     = b_write_data;
    end else if (wr_grant_a_s) begin
      m_write_row_addr = a_write_row_addr;
      m_write_data     = a_write_data;
    end else begin
      m_write_row_addr = {ADDR_W{1'b0}};
      m_write_data     = {ROW_W{1'b0}};
    end
    a_row_addr_ack = rd_grant_a_s;
    b_row_addr_ack = rd_grant_b_s;
    a_write_ack    = wr_grant_a_s;
    b_write_ack    = wr_grant_b_s;
    a_row_valid    = pop_s & (pop_owner_s == OWNER_A);
    b_row_valid    = pop_s & (pop_owner_s == OWNER_B);
    row_out        = rst ? {ROW_W{1'b0}} : m_row_out;
  end

  // Round-robin history and sticky response error.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_last_a_q  <= 1'b0;
      wr_last_a_q  <= 1'b0;
      resp_error_q <= 1'b0;
    end else begin
      rd_last_a_q  <= rd_last_a_d;
      wr_last_a_q  <= wr_last_a_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign resp_error = resp_error_q;

  owner_fifo #(.DEPTH(FIFO_DEPTH)) u_owner_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (rd_grant_a_s | rd_grant_b_s),
    .push_owner_i (rd_grant_b_s ? OWNER_B : OWNER_A),
    .pop_i        (pop_s),
    .pop_owner_o  (pop_owner_s),
    .full_o       (fifo_full_s),
    .empty_o      (fifo_empty_s)
  );
endmodule

// File: tb/tb_r_port_arbiter.sv
// Directed self-checking bench for r_port_arbiter with a 2-cycle memory model.
module tb_r_port_arbiter;
  localparam int NUM_ROWS = 5, NUM_COLS = 5, SCALAR_BITS = 32, LAT = 2;
  localparam int ADDR_W = $clog2(NUM_ROWS);
  localparam int ROW_W  = NUM_COLS * SCALAR_BITS;

  logic clk, rst, mem_en, tb_init, inj_v;
  logic [ROW_W-1:0]  inj_data;
  logic [ADDR_W-1:0] m_row_addr, m_write_row_addr;
  logic              m_row_addr_ready, m_write_ready, m_row_valid, resp_error;
  logic [ROW_W-1:0]  m_write_data, m_row_out, row_out;
  logic [ROW_W-1:0]  mem [NUM_ROWS];
  logic [LAT-1:0]    pipe_v;
  logic [ADDR_W-1:0] pipe_a [LAT];
  int n_checks, n_pass;

  r_port_arbiter_if #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) a_bus ();
  r_port_arbiter_if #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) b_bus ();

  r_port_arbiter #(.NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS),
                   .SCALAR_BITS(SCALAR_BITS), .MEMORY_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .a_row_addr(a_bus.row_addr), .b_row_addr(b_bus.row_addr),
    .a_row_addr_ready(a_bus.row_addr_ready), .b_row_addr_ready(b_bus.row_addr_ready),
    .a_row_addr_ack(a_bus.row_addr_ack), .b_row_addr_ack(b_bus.row_addr_ack),
    .a_row_valid(a_bus.row_valid), .b_row_valid(b_bus.row_valid),
    .row_out(row_out),
    .a_write_row_addr(a_bus.write_row_addr), .b_write_row_addr(b_bus.write_row_addr),
    .a_write_data(a_bus.write_data), .b_write_data(b_bus.write_data),
    .a_write_ready(a_bus.write_ready), .b_write_ready(b_bus.write_ready),
    .a_write_ack(a_bus.write_ack), .b_write_ack(b_bus.write_ack),
    .m_row_addr(m_row_addr), .m_row_addr_ready(m_row_addr_ready),
    .m_write_row_addr(m_write_row_addr), .m_write_data(m_write_data),
    .m_write_ready(m_write_ready), .m_row_valid(m_row_valid),
    .m_row_out(m_row_out), .resp_error(resp_error)
  );

  function automatic logic [ROW_W-1:0] pat(input int r);
    logic [31:0] s;
    s = 32'hC0DE_0000 + 32'(r);
    return {NUM_COLS{s}};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural row_matrix: fixed-latency reads, writes on the issuing edge.
  always @(posedge clk) begin
    if (tb_init) begin
      for (int r = 0; r < NUM_ROWS; r++) mem[r] <= pat(r);
    end else if (m_write_ready) begin
      mem[m_write_row_addr] <= m_write_data;
    end
    pipe_v[0] <= mem_en & m_row_addr_ready;
    pipe_a[0] <= m_row_addr;
    pipe_v[1] <= pipe_v[0];
    pipe_a[1] <= pipe_a[0];
  end

  assign m_row_valid = mem_en ? pipe_v[LAT-1] : inj_v;
  assign m_row_out   = mem_en ? mem[pipe_a[LAT-1]] : inj_data;

  task automatic check_eq(input string tag, input logic [ROW_W-1:0] got,
                          input logic [ROW_W-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic clear_reqs;
    a_bus.row_addr_ready = 1'b0; b_bus.row_addr_ready = 1'b0;
    a_bus.write_ready = 1'b0;    b_bus.write_ready = 1'b0;
    a_bus.row_addr = '0;         b_bus.row_addr = '0;
    a_bus.write_row_addr = '0;   b_bus.write_row_addr = '0;
    a_bus.write_data = '0;       b_bus.write_data = '0;
    inj_v = 1'b0;
  endtask

  task automatic do_reset(input logic en);
    tick;
    rst = 1'b1;
    clear_reqs();
    mem_en = en;
    tick; tick; tick;
    rst = 1'b0;
  endtask

  logic [3:0] exp_rr [7];
  logic [2:0] exp_st [7];

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; mem_en = 1'b1; tb_init = 1'b1; inj_data = '0;
    clear_reqs();

    // Reset holds everything low even with a request pending.
    tick;
    tb_init = 1'b0;
    a_bus.row_addr_ready = 1'b1; a_bus.row_addr = 3'd3;
    #1;
    check_eq("rst_ack", a_bus.row_addr_ack, 1'b0);
    check_eq("rst_m_ready", m_row_addr_ready, 1'b0);
    check_eq("rst_row_out", row_out, '0);
    check_eq("rst_err", resp_error, 1'b0);

    // Single read of row 3 by A.
    tick; rst = 1'b0; #1;
    check_eq("a_ack_same_cycle", a_bus.row_addr_ack, 1'b1);
    check_eq("m_addr_row3", m_row_addr, 3'd3);
    check_eq("b_ack_idle", b_bus.row_addr_ack, 1'b0);
    tick; a_bus.row_addr_ready = 1'b0; #1;
    check_eq("a_valid_early", a_bus.row_valid, 1'b0);
    tick; #1;
    check_eq("a_valid_lat", {a_bus.row_valid, b_bus.row_valid}, 2'b10);
    check_eq("row3_data", row_out, pat(3));
    tick; #1;
    check_eq("a_valid_pulse", a_bus.row_valid, 1'b0);

    // Contention: {a_ack, b_ack, a_valid, b_valid} per cycle.
    exp_rr = '{4'b1000, 4'b0100, 4'b1010, 4'b0101, 4'b0010, 4'b0001, 4'b0000};
    do_reset(1'b1);
    for (int c = 0; c < 7; c++) begin
      tick;
      a_bus.row_addr_ready = (c < 4); a_bus.row_addr = 3'd1;
      b_bus.row_addr_ready = (c < 4); b_bus.row_addr = 3'd4;
      #1;
      check_eq($sformatf("rr_c%0d", c), {a_bus.row_addr_ack, b_bus.row_addr_ack,
               a_bus.row_valid, b_bus.row_valid}, exp_rr[c]);
      if (c == 2) check_eq("rr_data_a", row_out, pat(1));
      if (c == 3) check_eq("rr_data_b", row_out, pat(4));
    end

    // Stalled memory: {b_ack, a_valid, b_valid}; one response frees one slot.
    exp_st = '{3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b101, 3'b000};
    do_reset(1'b0);
    inj_data = pat(9);
    for (int c = 0; c < 7; c++) begin
      tick;
      b_bus.row_addr_ready = 1'b1; b_bus.row_addr = 3'd2;
      inj_v = (c == 5);
      #1;
      check_eq($sformatf("stall_c%0d", c), {b_bus.row_addr_ack, a_bus.row_valid,
               b_bus.row_valid}, exp_st[c]);
      if (c == 5) check_eq("stall_data", row_out, pat(9));
    end

    // Reset with reads outstanding: late responses are errors, not data.
    tick; b_bus.row_addr_ready = 1'b0; inj_v = 1'b0; rst = 1'b1; #1;
    check_eq("rst_outst_ack", m_row_addr_ready, 1'b0);
    tick; tick; rst = 1'b0;
    tick; inj_v = 1'b1; #1;
    check_eq("late_valid0", {a_bus.row_valid, b_bus.row_valid}, 2'b00);
    tick; #1;
    check_eq("late_valid1", {a_bus.row_valid, b_bus.row_valid}, 2'b00);
    check_eq("late_err", resp_error, 1'b1);
    tick; inj_v = 1'b0; tick; tick; #1;
    check_eq("err_sticky", resp_error, 1'b1);
    tick; rst = 1'b1; tick; #1;
    check_eq("err_cleared", resp_error, 1'b0);

    // Spurious response with nothing outstanding.
    tick; rst = 1'b0;
    tick; inj_v = 1'b1; #1;
    check_eq("spur_valid", {a_bus.row_valid, b_bus.row_valid}, 2'b00);
    check_eq("spur_err_reg", resp_error, 1'b0);
    tick; inj_v = 1'b0; #1;
    check_eq("spur_err", resp_error, 1'b1);

    // Concurrent write (A, row 1) and read (B, row 2), then write contention.
    do_reset(1'b1);
    tick;
    a_bus.write_ready = 1'b1; a_bus.write_row_addr = 3'd1; a_bus.write_data = pat(101);
    b_bus.row_addr_ready = 1'b1; b_bus.row_addr = 3'd2;
    #1;
    check_eq("wr_rd_acks", {a_bus.write_ack, b_bus.write_ack, b_bus.row_addr_ack},
             3'b101);
    check_eq("wr_rd_m", {m_write_ready, m_row_addr_ready}, 2'b11);
    check_eq("wr_m_addr", m_write_row_addr, 3'd1);
    check_eq("wr_m_data", m_write_data, pat(101));
    check_eq("rd_m_addr", m_row_addr, 3'd2);
    tick;
    b_bus.row_addr_ready = 1'b0;
    a_bus.write_row_addr = 3'd0; a_bus.write_data = pat(100);
    b_bus.write_ready = 1'b1; b_bus.write_row_addr = 3'd4; b_bus.write_data = pat(104);
    #1;
    check_eq("wr_rr_b", {a_bus.write_ack, b_bus.write_ack}, 2'b01);
    check_eq("wr_rr_b_addr", m_write_row_addr, 3'd4);
    tick; #1;
    check_eq("wr_rr_a", {a_bus.write_ack, b_bus.write_ack}, 2'b10);
    check_eq("wr_rr_a_data", m_write_data, pat(100));
    check_eq("rd_b_valid", {a_bus.row_valid, b_bus.row_valid}, 2'b01);
    check_eq("rd_b_data", row_out, pat(2));
    tick;
    a_bus.write_ready = 1'b0; b_bus.write_ready = 1'b0;
    a_bus.row_addr_ready = 1'b1; a_bus.row_addr = 3'd1;
    #1;
    check_eq("rb_ack", a_bus.row_addr_ack, 1'b1);
    tick; a_bus.row_addr_ready = 1'b0;
    tick; #1;
    check_eq("rb_valid", a_bus.row_valid, 1'b1);
    check_eq("rb_data", row_out, pat(101));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/r_port_arbiter.md
R_PORT_ARBITER -- requirements
Module: r_port_arbiter

Interface
REQ-001 Parameter NUM_ROWS, default 5: rows of the shared row_matrix.
REQ-002 Parameter NUM_COLS, default 5: scalars per row.
REQ-003 Parameter SCALAR_BITS, default 32: bits per scalar.
REQ-004 Parameter MEMORY_LATENCY, default 2: row_matrix read latency in cycles.
REQ-005 The port `clk` SHALL be: input, 1 bit, the single clock.
REQ-006 The port `rst` SHALL be: input, 1 bit, synchronous, active-high reset.
REQ-007 The ports `{a,b}_row_addr` SHALL be: input, $clog2(NUM_ROWS) bits each, read row address of requester A (compute engine) and requester B (host/readout).
REQ-008 The ports `{a,b}_row_addr_ready` SHALL be: input, 1 bit each, read request, held high until acknowledged.
REQ-009 The ports `{a,b}_row_addr_ack` SHALL be: output, 1 bit each, one-cycle pulse, read request issued to memory.
REQ-010 The ports `{a,b}_row_valid` SHALL be: output, 1 bit each, read data returned to that requester.
REQ-011 The port `row_out` SHALL be: output, NUM_COLS*SCALAR_BITS bits, read data broadcast to both requesters.
REQ-012 The ports `{a,b}_write_row_addr` and `{a,b}_write_data` SHALL be: input, address width and row width respectively, write request payload.
REQ-013 The ports `{a,b}_write_ready` SHALL be: input, 1 bit each, write request, held until acknowledged.
REQ-014 The ports `{a,b}_write_ack` SHALL be: output, 1 bit each, one-cycle pulse, write issued.
REQ-015 The ports `m_row_addr`, `m_row_addr_ready`, `m_write_row_addr`, `m_write_data` and `m_write_ready` SHALL be: output, matching widths, the row_matrix port.
REQ-016 The ports `m_row_valid` and `m_row_out` SHALL be: input, 1 bit and row width, the row_matrix read response.
REQ-017 The port `resp_error` SHALL be: output, 1 bit, sticky flag set on an unexpected response.

Function
REQ-018 The read and write channels SHALL be arbitrated independently and may both issue in the same cycle.
REQ-019 Per channel, when exactly one requester is high, the arbiter SHALL grant it that cycle.
REQ-020 Per channel, when both requesters are high, the arbiter SHALL grant the one not granted last on that channel (round-robin); the first conflict after reset SHALL grant A.
REQ-021 A grant SHALL drive the m_* request combinationally in the same cycle, pulse the matching ack for one cycle, and update the last-granted bit on the next edge.
REQ-022 A requester SHALL see its ack no later than the second cycle of contention (starvation bound of 1 cycle).
REQ-023 Each issued read SHALL push the owner ID (0=A, 1=B) into an owner FIFO of depth MEMORY_LATENCY+1.
REQ-024 Each m_row_valid SHALL pop the FIFO and assert the popped owner's {a,b}_row_valid in the same cycle; the other requester's valid SHALL stay low; row_out SHALL equal m_row_out.
REQ-025 When the FIFO is full and no pop occurs that cycle, read grants SHALL be withheld; a push and a pop in the same cycle SHALL be legal at any occupancy.
REQ-026 m_row_valid with the FIFO empty SHALL set resp_error, route to neither requester, and leave the FIFO unchanged.
REQ-027 Writes SHALL have no response tracking; the ack alone signals completion.
REQ-028 Same-row read and write in one cycle SHALL both be issued unmodified; ordering is defined by row_matrix.

Reset
REQ-029 While rst is high, all outputs SHALL be 0, the FIFO SHALL be emptied, the last-granted bits SHALL be cleared, and resp_error SHALL be cleared.
REQ-030 Responses to reads issued before reset SHALL be dropped and SHALL set resp_error if they arrive after reset deasserts.

Structure
REQ-031 The owner ID encoding and the FIFO depth function SHALL live in the shared package.
REQ-032 The owner FIFO SHALL be a separate sub-module, owner_fifo, parameterized on depth.
REQ-033 The arbiter SHALL introduce no registered stage on the request path.

Verification
REQ-034 A reads row 3 alone -> a_row_addr_ack in the same cycle; a_row_valid exactly MEMORY_LATENCY cycles later with row 3 data; b_row_valid stays 0.
REQ-035 A and B hold read requests for 4 cycles after reset -> acks in order A, B, A, B; the valids return in the same owner order.
REQ-036 B requests reads continuously with the memory response stalled -> after MEMORY_LATENCY+1 grants, acks stop until an m_row_valid arrives.
REQ-037 A writes row 1 and B reads row 2 in the same cycle -> both acks pulse; m_write_ready and m_row_addr_ready are both high.
REQ-038 rst is asserted with 2 reads outstanding -> the FIFO empties; the late m_row_valid pulses set resp_error and produce no {a,b}_row_valid.
REQ-039 m_row_valid is injected with no read outstanding -> resp_error=1 and stays 1 until rst.
